intr_ctrl: RTL and testbench
============================

# intr_ctrl

Interrupt controller that sequences the OTTER CSR interrupt path. It latches rising edges on up to N_SRC external interrupt lines and applies a per-source mask and priority. It handshakes with the CPU control FSM at an instruction boundary, then drives the one-cycle INT_TAKEN strobe that makes the CSR capture MEPC and clear MIE. It sits between the peripheral IRQ lines, the CPU control unit and the CSR block, and tracks the in-service state until MRET.

## Interface
- N_SRC, 4, number of interrupt sources; legal range 2..16.
- ID_W, $clog2(N_SRC), width of the source index.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IRQ  in  N_SRC  interrupt lines; a 0→1 transition requests service.
- CSR_MIE  in  1  global enable from CSR.
- MASK_WE  in  1  write strobe for mask register.
- MASK_WD  in  N_SRC  mask write data; 1 = source enabled.
- INT_ACK  in  1  CPU FSM at instruction boundary, accepting the request.
- MRET  in  1  one-cycle pulse when CPU executes MRET.
- INT_REQ  out  1  interrupt request to CPU FSM.
- INT_TAKEN  out  1  one-cycle strobe to CSR INT_TAKEN and CPU (load PC ← MTVEC).
- INT_ID  out  ID_W  index of the source being or last taken.
- PENDING  out  N_SRC  latched pending bits (software-visible).
- MASK  out  N_SRC  current mask register.
- IN_SERVICE  out  1  high from INT_TAKEN until MRET accepted.

## Operation
- Reset values: INT_REQ=0, INT_TAKEN=0, INT_ID=0, PENDING=0, IN_SERVICE=0, MASK=all ones, IRQ history flops=0, state IDLE.
- Edge detect: PENDING[i] is set at the edge where IRQ[i] is 1 and the previous sample was 0. Level-high without an edge does not re-set it.
- Mask: MASK ← MASK_WD on MASK_WE. Masked sources still latch PENDING; they are only excluded from selection.
- Selection: eligible = PENDING & MASK. The winner is the lowest set index (index 0 is highest priority).
- INT_REQ = (state==PEND) && |eligible && CSR_MIE (combinational qualifier; never presents a stale request).
- FSM:
  - IDLE→PEND when |eligible && CSR_MIE.
  - PEND→IDLE when !(|eligible && CSR_MIE).
  - PEND→TAKE when INT_REQ && INT_ACK. At that edge:
    - INT_ID ← winner.
    - PENDING[winner] ← 0, unless a new edge on that source arrives in the same cycle (set wins).
  - TAKE→SERVICE unconditionally. INT_TAKEN=1 only in TAKE.
  - SERVICE→IDLE on MRET. IN_SERVICE=1 in TAKE and SERVICE.
- No nesting. While in SERVICE, new edges latch into PENDING and are served after MRET, provided software has re-enabled MIE.
- MRET in IDLE/PEND/TAKE is ignored. INT_ACK outside PEND is ignored.
- Multiple simultaneous edges all latch. They are served one per service cycle in priority order.

## Timing
- IRQ edge sampled at edge k → PENDING set after k → state PEND after k+1 → INT_REQ visible in cycle k+2 (when MIE=1 and unmasked).
- INT_ACK sampled high at edge a → INT_TAKEN high for exactly cycle a+1 → IN_SERVICE high from a+1.
- MRET sampled at edge m → IDLE after m. A still-eligible source raises INT_REQ again no earlier than cycle m+2.
- RST mid-operation (any state) returns all outputs and state to reset values on that edge. Edges on the reset cycle are dropped.

## Configuration
- INTR_SYNC_EN defined: each IRQ bit passes through a 2-flop synchronizer (reset 0) before edge detection. IRQ-to-INT_REQ latency becomes k+4.
- INTR_SYNC_EN undefined: IRQ is sampled directly. IRQ must be synchronous to CLK. Latency is as in Timing.

## Structure
- Package intr_pkg: state typedef (IDLE, PEND, TAKE, SERVICE), N_SRC_MAX=16 constant.
- Sub-module irq_edge: per-source optional synchronizer plus edge detector, producing a one-cycle rise pulse vector.
- Priority encoder, mask and FSM live in intr_ctrl.

## Test plan
- Single source: N_SRC=4, MIE=1, IRQ[2] 0→1 at edge 10 → INT_REQ in cycle 12; ACK at edge 13 → INT_TAKEN cycle 14 only, INT_ID=2, PENDING=0000, IN_SERVICE=1; MRET → IN_SERVICE=0.
- Priority: IRQ[3] and IRQ[1] rise same cycle, ACK → INT_ID=1, PENDING=1000. After MRET with MIE=1, second ACK → INT_ID=3.
- Mask/MIE gating:
  - MASK=1011 and IRQ[2] edge → PENDING=0100, INT_REQ stays 0.
  - Write MASK=1111 → INT_REQ rises.
  - MIE=0 while in PEND → INT_REQ drops next cycle, state IDLE.
- During SERVICE, IRQ[0] edge → PENDING=0001, no INT_REQ until after MRET. Stray MRET in IDLE → no state change.
- Same-cycle set/clear: IRQ[0] edge on the ACK edge selecting source 0 → PENDING[0] remains 1.
- Reset in SERVICE with PENDING=0110 → all outputs at reset values, MASK=1111 next cycle.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types and limits for the OTTER interrupt controller.
// Holds the controller state encoding and the supported source count ceiling.
package intr_pkg;

  localparam int unsigned N_SRC_MAX = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    TAKE    = 2'd2,
    SERVICE = 2'd3
  } state_t;

endpackage

// File: rtl/irq_edge.sv
// Per-source rising-edge detector for the interrupt lines.
// With INTR_SYNC_EN defined, each line first passes through a 2-flop synchronizer.
module irq_edge #(
  parameter int unsigned N_SRC = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] irq,
  output logic [N_SRC-1:0] rise
);

  logic [N_SRC-1:0] samp;
  logic [N_SRC-1:0] hist_q, hist_d;

`ifdef INTR_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync1_d;
  logic [N_SRC-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq;
    sync2_d = sync1_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = irq;
`endif

  always_comb begin
    hist_d = samp;
    rise   = samp & ~hist_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) hist_q <= '0;
    else     hist_q <= hist_d;
  end

endmodule

// File: rtl/intr_ctrl.sv
// OTTER interrupt controller: edge latching, mask, fixed priority and CPU handshake.
// Optional INTR_SYNC_EN macro adds a 2-flop IRQ synchronizer in irq_edge.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             CSR_MIE,
  input  logic             MASK_WE,
  input  logic [N_SRC-1:0] MASK_WD,
  input  logic             INT_ACK,
  input  logic             MRET,
  output logic             INT_REQ,
  output logic             INT_TAKEN,
  output logic [ID_W-1:0]  INT_ID,
  output logic [N_SRC-1:0] PENDING,
  output logic [N_SRC-1:0] MASK,
  output logic             IN_SERVICE
);

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  winner;
  logic             req_ok;
  logic             take;

  irq_edge #(.N_SRC(N_SRC)) u_edge (
    .CLK  (CLK),
    .RST  (RST),
    .irq  (IRQ),
    .rise (rise)
  );

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    eligible = pending_q & mask_q;
    winner   = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (eligible[i-1]) winner = ID_W'(i - 1);
    end
    req_ok = (|eligible) && CSR_MIE;
    take   = (state_q == PEND) && req_ok && INT_ACK;
  end

  // Clear of the served bit is applied before new edges so a same-cycle edge wins.
  always_comb begin
    pending_d = pending_q;
    if (take) pending_d[winner] = 1'b0;
    pending_d = pending_d | rise;
    mask_d    = MASK_WE ? MASK_WD : mask_q;
    int_id_d  = take ? winner : int_id_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_ok) state_d = PEND;
      PEND: begin
        if (!req_ok)      state_d = IDLE;
        else if (INT_ACK) state_d = TAKE;
      end
      TAKE:    state_d = SERVICE;
      SERVICE: if (MRET) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '1;
      int_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      int_id_q  <= int_id_d;
    end
  end

  always_comb begin
    INT_REQ    = (state_q == PEND) && req_ok;
    INT_TAKEN  = (state_q == TAKE);
    IN_SERVICE = (state_q == TAKE) || (state_q == SERVICE);
    INT_ID     = int_id_q;
    PENDING    = pending_q;
    MASK       = mask_q;
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed, table-driven bench for intr_ctrl (default build, N_SRC=4).
// Each table row is one clock cycle: drive inputs, check outputs, then clock.
module tb_intr_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] IRQ;
  logic       CSR_MIE;
  logic       MASK_WE;
  logic [3:0] MASK_WD;
  logic       INT_ACK;
  logic       MRET;
  logic       INT_REQ;
  logic       INT_TAKEN;
  logic [1:0] INT_ID;
  logic [3:0] PENDING;
  logic [3:0] MASK;
  logic       IN_SERVICE;

  int errors = 0;
  int checks = 0;

  intr_ctrl #(.N_SRC(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IRQ        (IRQ),
    .CSR_MIE    (CSR_MIE),
    .MASK_WE    (MASK_WE),
    .MASK_WD    (MASK_WD),
    .INT_ACK    (INT_ACK),
    .MRET       (MRET),
    .INT_REQ    (INT_REQ),
    .INT_TAKEN  (INT_TAKEN),
    .INT_ID     (INT_ID),
    .PENDING    (PENDING),
    .MASK       (MASK),
    .IN_SERVICE (IN_SERVICE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  typedef struct {
    logic       we;
    logic [3:0] wd;
    logic [3:0] irq;
    logic       mie;
    logic       ack;
    logic       mret;
    logic       req;
    logic       taken;
    logic [1:0] id;
    logic [3:0] pend;
    logic       svc;
    logic [3:0] mask;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input logic [3:0] wd, input logic [3:0] irq,
                     input logic mie, input logic ack, input logic mret,
                     input logic req, input logic taken, input logic [1:0] id,
                     input logic [3:0] pend, input logic svc, input logic [3:0] mask);
    vec_t v;
    v.we = we; v.wd = wd; v.irq = irq; v.mie = mie; v.ack = ack; v.mret = mret;
    v.req = req; v.taken = taken; v.id = id; v.pend = pend; v.svc = svc; v.mask = mask;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic taken,
                         input logic [1:0] id, input logic [3:0] pend,
                         input logic svc, input logic [3:0] mask);
    chk({tag, ".INT_REQ"},    32'(INT_REQ),    32'(req));
    chk({tag, ".INT_TAKEN"},  32'(INT_TAKEN),  32'(taken));
    chk({tag, ".INT_ID"},     32'(INT_ID),     32'(id));
    chk({tag, ".PENDING"},    32'(PENDING),    32'(pend));
    chk({tag, ".IN_SERVICE"}, 32'(IN_SERVICE), 32'(svc));
    chk({tag, ".MASK"},       32'(MASK),       32'(mask));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //   we wd     irq     mie ack mret  req tk id pend    svc mask
    // single source 2
    add(0, 4'h0, 4'b0000, 1, 0, 0,   0, 0, 0, 4'b0000, 0, 4'b1111); // v0
    add(0, 4'h0, 4'b0100, 1, 0, 0,   0, 0, 0, 4'b0000, 0, 4'b1111); // v1 edge k
    add(0, 4'h0, 4'b0100, 1, 0, 0,   0, 0, 0, 4'b0100, 0, 4'b1111);
    add(0, 4'h0, 4'b0100, 1, 0, 0,   1, 0, 0, 4'b0100, 0, 4'b1111); // req at k+2
    add(0, 4'h0, 4'b0100, 1, 1, 0,   1, 0, 0, 4'b0100, 0, 4'b1111); // ack
    add(0, 4'h0, 4'b0100, 1, 0, 0,   0, 1, 2, 4'b0000, 1, 4'b1111); // TAKE
    add(0, 4'h0, 4'b0100, 1, 0, 0,   0, 0, 2, 4'b0000, 1, 4'b1111);
    add(0, 4'h0, 4'b0100, 1, 0, 1,   0, 0, 2, 4'b0000, 1, 4'b1111); // mret
    add(0, 4'h0, 4'b0000, 1, 0, 0,   0, 0, 2, 4'b0000, 0, 4'b1111);
    // priority 3 vs 1
    add(0, 4'h0, 4'b1010, 1, 0, 0,   0, 0, 2, 4'b0000, 0, 4'b1111);
    add(0, 4'h0, 4'b1010, 1, 0, 0,   0, 0, 2, 4'b1010, 0, 4'b1111);
    add(0, 4'h0, 4'b1010, 1, 1, 0,   1, 0, 2, 4'b1010, 0, 4'b1111);
    add(0, 4'h0, 4'b1010, 1, 0, 0,   0, 1, 1, 4'b1000, 1, 4'b1111);
    add(0, 4'h0, 4'b1010, 1, 0, 1,   0, 0, 1, 4'b1000, 1, 4'b1111); // mret at m
    add(0, 4'h0, 4'b1010, 1, 0, 0,   0, 0, 1, 4'b1000, 0, 4'b1111); // m+1: IDLE
    add(0, 4'h0, 4'b1010, 1, 1, 0,   1, 0, 1, 4'b1000, 0, 4'b1111); // m+2: req
    add(0, 4'h0, 4'b1010, 1, 0, 0,   0, 1, 3, 4'b0000, 1, 4'b1111);
    add(0, 4'h0, 4'b1010, 1, 0, 1,   0, 0, 3, 4'b0000, 1, 4'b1111);
    add(0, 4'h0, 4'b0000, 1, 0, 0,   0, 0, 3, 4'b0000, 0, 4'b1111);
    // mask and MIE gating
    add(1, 4'hB, 4'b0000, 1, 0, 0,   0, 0, 3, 4'b0000, 0, 4'b1111);
    add(0, 4'h0, 4'b0100, 1, 0, 0,   0, 0, 3, 4'b0000, 0, 4'b1011);
    add(0, 4'h0, 4'b0100, 1, 0, 0,   0, 0, 3, 4'b0100, 0, 4'b1011); // masked: latched
    add(1, 4'hF, 4'b0100, 1, 0, 0,   0, 0, 3, 4'b0100, 0, 4'b1011);
    add(0, 4'h0, 4'b0100, 1, 0, 0,   0, 0, 3, 4'b0100, 0, 4'b1111);
    add(0, 4'h0, 4'b0100, 1, 0, 0,   1, 0, 3, 4'b0100, 0, 4'b1111);
    add(0, 4'h0, 4'b0100, 0, 0, 0,   0, 0, 3, 4'b0100, 0, 4'b1111); // MIE off in PEND
    add(0, 4'h0, 4'b0100, 1, 0, 0,   0, 0, 3, 4'b0100, 0, 4'b1111); // back in IDLE
    add(0, 4'h0, 4'b0100, 1, 1, 0,   1, 0, 3, 4'b0100, 0, 4'b1111);
    add(0, 4'h0, 4'b0000, 1, 0, 0,   0, 1, 2, 4'b0000, 1, 4'b1111);
    // edge during service, stray mrets
    add(0, 4'h0, 4'b0001, 1, 0, 0,   0, 0, 2, 4'b0000, 1, 4'b1111);
    add(0, 4'h0, 4'b0001, 1, 0, 0,   0, 0, 2, 4'b0001, 1, 4'b1111);
    add(0, 4'h0, 4'b0001, 1, 0, 0,   0, 0, 2, 4'b0001, 1, 4'b1111);
    add(0, 4'h0, 4'b0001, 1, 0, 1,   0, 0, 2, 4'b0001, 1, 4'b1111);
    add(0, 4'h0, 4'b0000, 1, 0, 1,   0, 0, 2, 4'b0001, 0, 4'b1111); // mret in IDLE
    add(0, 4'h0, 4'b0001, 1, 1, 0,   1, 0, 2, 4'b0001, 0, 4'b1111); // ack + new edge
    add(0, 4'h0, 4'b0001, 1, 0, 1,   0, 1, 0, 4'b0001, 1, 4'b1111); // set wins; mret in TAKE
    add(0, 4'h0, 4'b0001, 1, 0, 0,   0, 0, 0, 4'b0001, 1, 4'b1111);
    add(0, 4'h0, 4'b0001, 1, 0, 1,   0, 0, 0, 4'b0001, 1, 4'b1111);
    add(0, 4'h0, 4'b0001, 1, 0, 0,   0, 0, 0, 4'b0001, 0, 4'b1111);
    add(0, 4'h0, 4'b0001, 1, 0, 0,   1, 0, 0, 4'b0001, 0, 4'b1111);

    RST = 1'b1; IRQ = '0; CSR_MIE = 1'b0; MASK_WE = 1'b0; MASK_WD = '0;
    INT_ACK = 1'b0; MRET = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 0, 2'd0, 4'b0000, 0, 4'b1111);
    RST = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      MASK_WE = vq[i].we;  MASK_WD = vq[i].wd;  IRQ  = vq[i].irq;
      CSR_MIE = vq[i].mie; INT_ACK = vq[i].ack; MRET = vq[i].mret;
      #1;
      chk_all($sformatf("v%0d", i), vq[i].req, vq[i].taken, vq[i].id,
              vq[i].pend, vq[i].svc, vq[i].mask);
      tick();
    end

    // Reset while in SERVICE with sources 1 and 2 pending and a non-default mask.
    MASK_WE = 0; MRET = 0; INT_ACK = 1; IRQ = 4'b0111;
    #1;
    chk("rst_seq.req_before_ack", 32'(INT_REQ), 32'd1);
    tick();
    INT_ACK = 0; MASK_WE = 1; MASK_WD = 4'b0101;
    #1;
    chk_all("rst_seq.take", 0, 1, 2'd0, 4'b0110, 1, 4'b1111);
    tick();
    MASK_WE = 0;
    #1;
    chk_all("rst_seq.service", 0, 0, 2'd0, 4'b0110, 1, 4'b0101);
    RST = 1; IRQ = 4'b0000;
    tick();
    RST = 0;
    #1;
    chk_all("rst_seq.after_rst", 0, 0, 2'd0, 4'b0000, 0, 4'b1111);
    tick();
    chk_all("rst_seq.idle", 0, 0, 2'd0, 4'b0000, 0, 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
